// File: rtl/term_cmd_parser.sv
// Terminal command decoder for the AVR USB byte stream: "r\r", "m0\r", "m1\r", "d0\r", "d1\r".
// Drives motor arm / datalog enable levels and a fixed-width system reset request pulse.
module term_cmd_parser #(
    parameter int TIMEOUT_TICKS = 4,
    parameter int RST_PULSE     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tmr,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic       motor_arm,
    output logic       datalog_en,
    output logic       sys_rst_req,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic [1:0] cmd_code
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int RW = $clog2(RST_PULSE + 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_M  = 8'h6D;
    localparam logic [7:0] CH_D  = 8'h64;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_R    = 2'd1;
    localparam logic [1:0] CODE_M    = 2'd2;
    localparam logic [1:0] CODE_D    = 2'd3;

    typedef enum logic [1:0] {IDLE, ARG, TERM} state_t;

    state_t          state, state_nx;
    logic [1:0]      pend_code, pend_code_nx;
    logic            arg, arg_nx;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   rcnt;
    logic            timeout_hit;
    logic            accept, reject;
    logic [1:0]      code_out;

    assign sys_rst_req = (rcnt != '0);

    // A byte in the same cycle as a tick always wins, so the tick never fires a timeout.
    assign timeout_hit = tmr && !new_rx_data && (state != IDLE)
                         && (tcnt == TW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_code <= CODE_NONE;
            arg       <= 1'b0;
        end else begin
            state     <= state_nx;
            pend_code <= pend_code_nx;
            arg       <= arg_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pend_code_nx = pend_code;
        arg_nx       = arg;
        if (new_rx_data) begin
            case (state)
                IDLE: begin
                    if (rx_data == CH_R) begin
                        state_nx     = TERM;
                        pend_code_nx = CODE_R;
                    end else if (rx_data == CH_M) begin
                        state_nx     = ARG;
                        pend_code_nx = CODE_M;
                    end else if (rx_data == CH_D) begin
                        state_nx     = ARG;
                        pend_code_nx = CODE_D;
                    end
                end
                ARG: begin
                    if (rx_data == CH_0 || rx_data == CH_1) begin
                        state_nx = TERM;
                        arg_nx   = rx_data[0];
                    end else begin
                        state_nx = IDLE;
                    end
                end
                TERM:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        code_out = CODE_NONE;
        if (new_rx_data) begin
            case (state)
                IDLE: begin
                    if (!(rx_data == CH_CR || rx_data == CH_LF || rx_data == CH_R
                          || rx_data == CH_M || rx_data == CH_D)) begin
                        reject = 1'b1;
                    end
                end
                ARG: begin
                    code_out = pend_code;
                    reject   = !(rx_data == CH_0 || rx_data == CH_1);
                end
                TERM: begin
                    code_out = pend_code;
                    // Arming the motors is refused while a system reset is in progress.
                    if (rx_data == CH_CR
                        && !(pend_code == CODE_M && arg && sys_rst_req)) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: reject = 1'b1;
            endcase
        end else if (timeout_hit) begin
            reject   = 1'b1;
            code_out = pend_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            motor_arm  <= 1'b0;
            datalog_en <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_code   <= CODE_NONE;
            rcnt       <= '0;
            tcnt       <= '0;
        end else begin
            cmd_valid <= accept;
            cmd_err   <= reject;
            if (accept || reject) begin
                cmd_code <= code_out;
            end

            if (accept && pend_code == CODE_M) begin
                motor_arm <= arg;
            end else if (accept && pend_code == CODE_R) begin
                motor_arm <= 1'b0;
            end
            if (accept && pend_code == CODE_D) begin
                datalog_en <= arg;
            end

            if (accept && pend_code == CODE_R) begin
                rcnt <= RW'(RST_PULSE);
            end else if (rcnt != '0) begin
                rcnt <= rcnt - 1'b1;
            end

            if (state == IDLE || state_nx == IDLE || new_rx_data) begin
                tcnt <= '0;
            end else if (tmr && tcnt != TW'(TIMEOUT_TICKS)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule
